// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
// ALU operation codes and sequencer state encodings.
package muldiv_unit_pkg;

    localparam int XLEN = 32;

    // Base ALU codes handled by the single-cycle alu
    localparam logic [5:0] ALU_ADD    = 6'd0;
    localparam logic [5:0] ALU_SUB    = 6'd1;
    localparam logic [5:0] ALU_AND    = 6'd2;
    localparam logic [5:0] ALU_OR     = 6'd3;
    localparam logic [5:0] ALU_XOR    = 6'd4;
    localparam logic [5:0] ALU_SLL    = 6'd5;
    localparam logic [5:0] ALU_SRL    = 6'd6;
    localparam logic [5:0] ALU_SRA    = 6'd7;
    localparam logic [5:0] ALU_SLT    = 6'd8;
    localparam logic [5:0] ALU_SLTU   = 6'd9;

    // M-extension codes routed to muldiv_unit
    localparam logic [5:0] ALU_MUL    = 6'd32;
    localparam logic [5:0] ALU_MULH   = 6'd33;
    localparam logic [5:0] ALU_MULHSU = 6'd34;
    localparam logic [5:0] ALU_MULHU  = 6'd35;
    localparam logic [5:0] ALU_DIV    = 6'd36;
    localparam logic [5:0] ALU_DIVU   = 6'd37;
    localparam logic [5:0] ALU_REM    = 6'd38;
    localparam logic [5:0] ALU_REMU   = 6'd39;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    function automatic logic is_mcode(input logic [5:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REMU);
    endfunction

    function automatic logic is_divcode(input logic [5:0] code);
        return (code >= ALU_DIV) && (code <= ALU_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M sequencer: shift-add multiply and restoring divide
// over one shared 64-bit register, 32 iterations per operation.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  alucode,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [5:0]  code_q, code_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        spec_q, spec_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;

    logic        sgn1, sgn2;
    logic        signed1, signed2;
    logic [31:0] abs1, abs2;
    logic        div0, ovf;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic        qbit;
    logic [31:0] rem_nx;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    // Operand sign handling for a new request
    always_comb begin
        signed1 = (alucode == ALU_MULH) || (alucode == ALU_MULHSU)
               || (alucode == ALU_DIV) || (alucode == ALU_REM);
        signed2 = (alucode == ALU_MULH) || (alucode == ALU_DIV)
               || (alucode == ALU_REM);
        sgn1 = op1[31] & signed1;
        sgn2 = op2[31] & signed2;
        abs1 = sgn1 ? (32'd0 - op1) : op1;
        abs2 = sgn2 ? (32'd0 - op2) : op2;
        div0 = is_divcode(alucode) && (op2 == 32'd0);
        ovf  = ((alucode == ALU_DIV) || (alucode == ALU_REM))
            && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    end

    // One restoring-division step and the sign-corrected final values
    always_comb begin
        rem_sh = {acc_q[63:32], a_q[cnt_q]};
        diff   = {1'b0, rem_sh} - {2'b00, b_q};
        qbit   = ~diff[33];
        rem_nx = qbit ? diff[31:0] : rem_sh[31:0];
        prod   = neg_q ? (64'd0 - acc_q) : acc_q;
        if (spec_q) begin
            quo = acc_q[31:0];
            rem = acc_q[63:32];
        end else begin
            quo = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
            rem = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end
    end

    // Next-state, datapath and result selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        spec_d   = spec_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            MD_IDLE, MD_DONE: begin
                state_d = MD_IDLE;
                if (start && is_mcode(alucode)) begin
                    code_d = alucode;
                    a_d    = abs1;
                    b_d    = abs2;
                    neg_d  = sgn1 ^ sgn2;
                    rneg_d = sgn1;
                    cnt_d  = 5'd31;
                    spec_d = div0 | ovf;
                    if (div0) begin
                        acc_d = {op1, 32'hFFFF_FFFF};
                    end else if (ovf) begin
                        acc_d = {32'd0, 32'h8000_0000};
                    end else begin
                        acc_d = 64'd0;
                    end
                    state_d = (div0 | ovf) ? MD_FIX : MD_CALC;
                end
            end
            MD_CALC: begin
                if (is_divcode(code_q)) begin
                    acc_d = {rem_nx, acc_q[30:0], qbit};
                end else begin
                    acc_d = {acc_q[62:0], 1'b0}
                          + (b_q[cnt_q] ? {32'd0, a_q} : 64'd0);
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                case (code_q)
                    ALU_MUL:                 result_d = prod[31:0];
                    ALU_MULH, ALU_MULHSU,
                    ALU_MULHU:               result_d = prod[63:32];
                    ALU_DIV, ALU_DIVU:       result_d = quo;
                    ALU_REM, ALU_REMU:       result_d = rem;
                    default:                 result_d = result_q;
                endcase
                state_d = MD_DONE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (kill) begin
            state_d  = MD_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= 5'd0;
            code_q   <= 6'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            spec_q   <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            spec_q   <= spec_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == MD_CALC) || (state_q == MD_FIX);
    assign done   = (state_q == MD_DONE);
    assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M sequencer sitting beside the single-cycle `alu` in the execute stage. It accepts MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU requests, iterates a shared shift-add / restoring-subtract datapath over 32 cycles, and stalls the pipeline via `busy` until a one-cycle `done` presents the result. The decoder routes M-extension `alucode` values here instead of to `alu`.

## Interface
- No parameters; width fixed at 32.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high.
- `start` in 1: request strobe, sampled only in IDLE or DONE.
- `alucode` in 6: operation, one of `ALU_MUL`, `ALU_MULH`, `ALU_MULHSU`, `ALU_MULHU`, `ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU`.
- `op1` in 32: rs1 value (multiplicand / dividend).
- `op2` in 32: rs2 value (multiplier / divisor).
- `kill` in 1: pipeline flush; aborts the operation in flight.
- `busy` out 1: high in CALC and FIX; pipeline holds the execute stage.
- `done` out 1: one-cycle pulse, `result` valid.
- `result` out 32: registered result; holds until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + `start` + M-code: latch operands, alucode and signs. Take absolute values for signed operands (MULH/DIV/REM: both; MULHSU: op1 only). Clear the 64-bit accumulator and load counter = 31.
  - Normal case: go to CALC.
  - Special case: go straight to FIX.
- IDLE/DONE + `start` + non-M code: ignored; go to or stay in IDLE.
- CALC, multiply: radix-2 shift-add of |op1|·|op2| into the 64-bit product, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; partial remainder is 33 bits wide.
- CALC: counter decrements each cycle. Exactly 32 cycles in CALC, then FIX.
- FIX: apply the sign correction and select the result; register `result`; go to DONE.
  - Product is negated if the operand signs differ.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
- Result select:
  - MUL: product[31:0].
  - MULH*, MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: `done`=1 for this cycle only, then IDLE unless a new `start` is accepted.
- Special cases (skip CALC):
  - Divisor 0: quotient 0xFFFFFFFF, remainder = op1.
  - DIV/REM with op1=0x80000000 and op2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `kill` in any state: next state IDLE, no `done`, `result` unchanged. `kill` wins over a same-cycle `start`.
- `start` while `busy`: ignored.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0.

## Timing
- `start` in cycle 0, normal op: `busy` high cycles 1–33 (CALC 1–32, FIX 33). `done` and `result` valid in cycle 34, `busy` low.
- Special case: FIX in cycle 1 (`busy`=1), `done` in cycle 2.
- Back-to-back: `start` accepted in the DONE cycle makes cycle 35 the first CALC of the next op.
- `rst` mid-operation: IDLE on the next edge; `done` never pulses for the aborted op.
- `busy` and `done` are decoded from registered state. `result` is a register. No combinational path from inputs to outputs.

## Structure
- Add `ALU_MUL`…`ALU_REMU` as eight new 6-bit codes in `define.vh`, distinct from every existing `ALU_*` value.
- Add state encodings `MD_IDLE`, `MD_CALC`, `MD_FIX`, `MD_DONE` (2 bits) to `define.vh`.
- Single module: one 64-bit shift register shared by multiply and divide. No sub-module; the sign/abs pre- and post-processing stays inline.

## Test plan
- MUL 7 × 0xFFFFFFFD → `done` at cycle 34, `result`=0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU → 0x00000006.
- MULHSU op1=0xFFFFFFFF, op2=0x00000002 → `result`=0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF (sign follows dividend).
- DIV 5/0 → `done` at cycle 2, 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 with REM 0.
- `kill` at cycle 10 of a DIV → IDLE at cycle 11, no `done`, `result` keeps its previous value; a same-cycle `start`+`kill` in IDLE → stays IDLE.
- `start` asserted every cycle → second op accepted only in the DONE cycle. `start` with `ALU_ADD` → no `busy`. `rst` at cycle 20 → all outputs 0 next cycle.
